// File: rtl/rat_pkg.sv
// Shared RAT MCU definitions: flag-load source encodings, synchroniser depth
// default, packed C/Z flag pair and a saturating counter helper.
package rat_pkg;

  localparam logic FLG_SRC_ALU  = 1'b0;
  localparam logic FLG_SRC_SHAD = 1'b1;

  localparam int SYNC_STAGES_DEFAULT = 2;

  localparam logic [15:0] INT_COUNT_MAX = 16'hFFFF;

  typedef struct packed {
    logic c;
    logic z;
  } flags_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == INT_COUNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/int_sync_edge.sv
// Synchroniser chain plus history flop for an asynchronous request; emits a
// one-cycle rise pulse per low-to-high transition of the synchronised level.
module int_sync_edge
  import rat_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT  // must be at least 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    hist_d = sync_q[SYNC_STAGES-1];
    if (rst) begin
      sync_d = '0;
      hist_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/flag_int_unit.sv
// RAT MCU status flags (C, Z, I, C/Z shadows) and interrupt front-end.
// Optional serviced-interrupt counter enabled by FLAG_INT_CNT_EN.
module flag_int_unit
  import rat_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rst,
  input  logic        c_alu,
  input  logic        z_alu,
  input  logic        flg_c_set,
  input  logic        flg_c_clr,
  input  logic        flg_c_ld,
  input  logic        flg_z_ld,
  input  logic        flg_ld_sel,
  input  logic        flg_shad_ld,
  input  logic        i_set,
  input  logic        i_clr,
  input  logic        int_ack,
  input  logic        int_req,
  output logic        c,
  output logic        z,
  output logic        i_flag,
`ifdef FLAG_INT_CNT_EN
  output logic [15:0] int_count,
`endif
  output logic        interrupt
);

  flags_t live_q, live_d;
  flags_t shad_q, shad_d;
  logic   i_q, i_d;
  logic   pending_q, pending_d;
  logic   rise;

  int_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .rst     (rst),
    .async_in(int_req),
    .rise    (rise)
  );

  always_comb begin
    live_d    = live_q;
    shad_d    = shad_q;
    i_d       = i_q;
    // A new edge wins over the ack so a request arriving during service is kept.
    pending_d = rise | (pending_q & ~int_ack);

    if (flg_c_clr)     live_d.c = 1'b0;
    else if (flg_c_set) live_d.c = 1'b1;
    else if (flg_c_ld)  live_d.c = (flg_ld_sel == FLG_SRC_SHAD) ? shad_q.c : c_alu;

    if (flg_z_ld) live_d.z = (flg_ld_sel == FLG_SRC_SHAD) ? shad_q.z : z_alu;

    // Shadows capture the pre-edge flags, even when C/Z change in the same cycle.
    if (flg_shad_ld) shad_d = live_q;

    if (int_ack)     i_d = 1'b0;
    else if (i_clr)  i_d = 1'b0;
    else if (i_set)  i_d = 1'b1;

    if (rst) begin
      live_d    = '0;
      shad_d    = '0;
      i_d       = 1'b0;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      live_q    <= '0;
      shad_q    <= '0;
      i_q       <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      live_q    <= live_d;
      shad_q    <= shad_d;
      i_q       <= i_d;
      pending_q <= pending_d;
    end
  end

`ifdef FLAG_INT_CNT_EN
  logic [15:0] int_count_q, int_count_d;

  always_comb begin
    int_count_d = int_count_q;
    // An ack with nothing pending is not a serviced interrupt.
    if (int_ack && pending_q) int_count_d = sat_inc16(int_count_q);
    if (rst) int_count_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) int_count_q <= '0;
    else          int_count_q <= int_count_d;
  end

  assign int_count = int_count_q;
`endif

  assign c         = live_q.c;
  assign z         = live_q.z;
  assign i_flag    = i_q;
  assign interrupt = pending_q & i_q;

endmodule

// File: tb/tb_flag_int_unit.sv
// Directed bench for flag_int_unit: table of flag-strobe vectors plus
// hand-written interrupt latency, coincidence, reset and counter sequences.
module tb_flag_int_unit;

  localparam int S = 2;

  logic clk = 1'b0;
  logic reset_n, rst;
  logic c_alu, z_alu, flg_c_set, flg_c_clr, flg_c_ld, flg_z_ld;
  logic flg_ld_sel, flg_shad_ld, i_set, i_clr, int_ack, int_req;
  logic c, z, i_flag, interrupt;
`ifdef FLAG_INT_CNT_EN
  logic [15:0] int_count;
`endif

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_cnt = 16'd0;

  always #5 clk = ~clk;

  flag_int_unit #(.SYNC_STAGES(S)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rst        (rst),
    .c_alu      (c_alu),
    .z_alu      (z_alu),
    .flg_c_set  (flg_c_set),
    .flg_c_clr  (flg_c_clr),
    .flg_c_ld   (flg_c_ld),
    .flg_z_ld   (flg_z_ld),
    .flg_ld_sel (flg_ld_sel),
    .flg_shad_ld(flg_shad_ld),
    .i_set      (i_set),
    .i_clr      (i_clr),
    .int_ack    (int_ack),
    .int_req    (int_req),
    .c          (c),
    .z          (z),
    .i_flag     (i_flag),
`ifdef FLAG_INT_CNT_EN
    .int_count  (int_count),
`endif
    .interrupt  (interrupt)
  );

  typedef struct {
    logic c_alu, z_alu, c_set, c_clr, c_ld, z_ld, ld_sel, shad_ld, i_set, i_clr;
    logic exp_c, exp_z, exp_i;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [9:0] strb, input logic [2:0] ex);
    vec_t v;
    {v.c_alu, v.z_alu, v.c_set, v.c_clr, v.c_ld, v.z_ld, v.ld_sel, v.shad_ld,
     v.i_set, v.i_clr} = strb;
    {v.exp_c, v.exp_z, v.exp_i} = ex;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_strobes();
    c_alu = 0; z_alu = 0; flg_c_set = 0; flg_c_clr = 0; flg_c_ld = 0;
    flg_z_ld = 0; flg_ld_sel = 0; flg_shad_ld = 0; i_set = 0; i_clr = 0;
    int_ack = 0;
  endtask

  task automatic check_count(input string name);
`ifdef FLAG_INT_CNT_EN
    check(name, int_count, exp_cnt);
`endif
  endtask

  task automatic pulse_ack();
    int_ack = 1; step(); int_ack = 0;
  endtask

  task automatic pulse_i_set();
    i_set = 1; step(); i_set = 0;
  endtask

  // Fresh request edge, wait for pending, then acknowledge.
  task automatic service();
    int_req = 0; steps(3);
    int_req = 1; steps(3);
    pulse_ack();
    if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
  endtask

  initial begin
    reset_n = 0; rst = 0; int_req = 1;
    clear_strobes();

    // Reset held with int_req high: everything stays zero.
    steps(3);
    check("rst_c", {15'd0, c}, 16'd0);
    check("rst_z", {15'd0, z}, 16'd0);
    check("rst_i", {15'd0, i_flag}, 16'd0);
    check("rst_int", {15'd0, interrupt}, 16'd0);
    check_count("rst_cnt");

    @(negedge clk); reset_n = 1;
    steps(4);
    check("post_rst_int", {15'd0, interrupt}, 16'd0);
    // Still-high int_req after reset counts as a fresh edge.
    pulse_i_set();
    check("fresh_edge_int", {15'd0, interrupt}, 16'd1);
    pulse_ack(); exp_cnt = exp_cnt + 16'd1;
    check("fresh_ack_int", {15'd0, interrupt}, 16'd0);
    check("fresh_ack_i", {15'd0, i_flag}, 16'd0);
    check_count("fresh_cnt");
    int_req = 0; steps(3);

    // bits: c_alu z_alu set clr c_ld z_ld sel shad i_set i_clr | c z i
    vecs.push_back(mk(10'b1_0_1_1_1_0_0_0_0_0, 3'b000));
    vecs.push_back(mk(10'b1_0_0_0_1_0_0_0_0_0, 3'b100));
    vecs.push_back(mk(10'b0_1_0_0_0_1_0_0_0_0, 3'b110));
    vecs.push_back(mk(10'b0_0_0_0_0_1_0_0_0_0, 3'b100));
    vecs.push_back(mk(10'b0_1_0_1_0_1_0_1_0_0, 3'b010));
    vecs.push_back(mk(10'b0_1_0_0_1_1_1_0_0_0, 3'b100));
    vecs.push_back(mk(10'b0_0_0_1_0_0_0_0_0_0, 3'b000));
    vecs.push_back(mk(10'b0_0_1_0_1_0_0_0_0_0, 3'b100));
    vecs.push_back(mk(10'b0_0_0_0_0_0_0_0_1_0, 3'b101));
    vecs.push_back(mk(10'b0_0_0_0_0_0_0_0_1_1, 3'b100));
    vecs.push_back(mk(10'b0_0_0_0_0_0_0_0_1_0, 3'b101));
    vecs.push_back(mk(10'b0_0_0_0_0_0_0_1_0_0, 3'b101));
    vecs.push_back(mk(10'b0_1_0_0_1_1_0_0_0_0, 3'b011));
    vecs.push_back(mk(10'b1_1_0_0_1_1_1_0_0_0, 3'b101));
    vecs.push_back(mk(10'b0_1_0_0_0_1_0_0_0_0, 3'b111));
    vecs.push_back(mk(10'b0_1_0_0_1_0_0_1_0_0, 3'b011));
    vecs.push_back(mk(10'b0_0_0_0_0_1_0_0_0_0, 3'b001));
    vecs.push_back(mk(10'b0_0_0_0_1_1_1_0_0_0, 3'b111));
    vecs.push_back(mk(10'b0_0_0_0_0_0_0_0_0_1, 3'b110));

    foreach (vecs[k]) begin
      c_alu = vecs[k].c_alu; z_alu = vecs[k].z_alu;
      flg_c_set = vecs[k].c_set; flg_c_clr = vecs[k].c_clr;
      flg_c_ld = vecs[k].c_ld; flg_z_ld = vecs[k].z_ld;
      flg_ld_sel = vecs[k].ld_sel; flg_shad_ld = vecs[k].shad_ld;
      i_set = vecs[k].i_set; i_clr = vecs[k].i_clr;
      step();
      clear_strobes();
      check($sformatf("vec%0d_c", k), {15'd0, c}, {15'd0, vecs[k].exp_c});
      check($sformatf("vec%0d_z", k), {15'd0, z}, {15'd0, vecs[k].exp_z});
      check($sformatf("vec%0d_i", k), {15'd0, i_flag}, {15'd0, vecs[k].exp_i});
      check($sformatf("vec%0d_int", k), {15'd0, interrupt}, 16'd0);
    end

    // Soft reset clears everything that was set.
    flg_c_set = 1; flg_z_ld = 1; z_alu = 1; i_set = 1; step(); clear_strobes();
    rst = 1; step(); rst = 0;
    check("soft_rst_flags", {13'd0, c, z, i_flag}, 16'd0);
    exp_cnt = 16'd0;
    check_count("soft_rst_cnt");

    // Latency: edge k samples the rise, interrupt high after edge k+S.
    pulse_i_set();
    int_req = 1;
    step(); check("lat_e0", {15'd0, interrupt}, 16'd0);
    step(); check("lat_e1", {15'd0, interrupt}, 16'd0);
    step(); check("lat_e2", {15'd0, interrupt}, 16'd1);
    pulse_ack(); exp_cnt = exp_cnt + 16'd1;
    check("ack_int", {15'd0, interrupt}, 16'd0);
    check("ack_i", {15'd0, i_flag}, 16'd0);
    // Level held high: no second request.
    steps(2); pulse_i_set(); steps(3);
    check("level_int", {15'd0, interrupt}, 16'd0);
    check("level_i", {15'd0, i_flag}, 16'd1);
    check_count("lat_cnt");

    // Coincident edge and ack: first request pending, second edge lands with ack.
    int_req = 0; steps(3);
    int_req = 1; steps(3);
    check("co_first_int", {15'd0, interrupt}, 16'd1);
    int_req = 0; steps(3);
    int_req = 1; steps(2);
    pulse_ack(); exp_cnt = exp_cnt + 16'd1;
    check("co_int_masked", {15'd0, interrupt}, 16'd0);
    check("co_i", {15'd0, i_flag}, 16'd0);
    pulse_i_set();
    check("co_pending_kept", {15'd0, interrupt}, 16'd1);
    pulse_ack(); exp_cnt = exp_cnt + 16'd1;
    check("co_cleared", {15'd0, interrupt}, 16'd0);
    check_count("co_cnt");

    // Illegal ack with nothing pending: clears I, counts nothing.
    pulse_i_set();
    pulse_ack();
    check("illegal_i", {15'd0, i_flag}, 16'd0);
    check_count("illegal_cnt");

    // Soft reset mid-request discards it; still-high request re-detected later.
    int_req = 0; steps(3);
    pulse_i_set();
    int_req = 1; step();
    rst = 1; step(); rst = 0;
    exp_cnt = 16'd0;
    check("mid_rst_int", {15'd0, interrupt}, 16'd0);
    check("mid_rst_i", {15'd0, i_flag}, 16'd0);
    steps(3); pulse_i_set();
    check("mid_rst_refill", {15'd0, interrupt}, 16'd1);
    pulse_ack(); exp_cnt = exp_cnt + 16'd1;
    check_count("mid_rst_cnt");

`ifdef FLAG_INT_CNT_EN
    service(); service(); service();
    check_count("cnt_three_more");
    force dut.int_count_q = 16'hFFFD;
    step();
    release dut.int_count_q;
    exp_cnt = 16'hFFFD;
    check_count("cnt_preload");
    service(); service();
    check_count("cnt_sat");
    service();
    check_count("cnt_no_wrap");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flag_int_unit.md
# flag_int_unit

Processor status and interrupt front-end for the RAT MCU. It holds the C, Z and I flags plus the C/Z shadow copies used across interrupt service. It also synchronises and latches the external interrupt request. It sits beside the control unit: it consumes the control unit's flag strobes and returns `c`, `z` and the gated `interrupt` input to it.

## Interface
- `SYNC_STAGES`, default 2: flip-flops in the int_req synchroniser; minimum 2.
- `clk` in, 1: system clock; all state updates on the rising edge.
- `reset_n` in, 1: asynchronous, active-low; clears all state.
- `rst` in, 1: synchronous soft reset from the control unit's init state; same clearing as `reset_n`.
- `c_alu`, `z_alu` in, 1 each: carry and zero from the ALU.
- `flg_c_set`, `flg_c_clr`, `flg_c_ld`, `flg_z_ld` in, 1 each: flag update strobes.
- `flg_ld_sel` in, 1: flag load source; 0 = ALU, 1 = shadow flags (RETID/RETIE).
- `flg_shad_ld` in, 1: copy live C/Z into the shadows.
- `i_set`, `i_clr` in, 1 each: SEI/CLI, and the I restore on RETIE/RETID.
- `int_ack` in, 1: control unit entering interrupt service; one-cycle pulse.
- `int_req` in, 1: external interrupt, asynchronous to `clk`.
- `c`, `z` out, 1 each: live flags, to the control unit and the ALU carry-in.
- `i_flag` out, 1: interrupt enable.
- `interrupt` out, 1: `pending & i_flag`, to the control unit.
- `int_count` out, 16: serviced-interrupt count. Present only with `FLAG_INT_CNT_EN`.

## Operation
- Reset:
  - `reset_n` low or `rst` high clears C, Z, the shadow C and shadow Z, I, `pending`, the synchroniser chain, the edge-history flop and `int_count`.
  - Every output is therefore 0 in reset.
- C update priority, highest first: `flg_c_clr`, then `flg_c_set`, then `flg_c_ld`. With `flg_c_ld`, C takes the shadow C if `flg_ld_sel` = 1, else `c_alu`.
- Z update: `flg_z_ld` loads the shadow Z if `flg_ld_sel` = 1, else `z_alu`.
- Shadows:
  - `flg_shad_ld` loads the shadows from the current registered C and Z, i.e. the pre-edge values.
  - If `flg_shad_ld` and a C/Z load occur in the same cycle, the shadow gets the old value.
- I flag priority, highest first: `int_ack`, then `i_clr`, then `i_set`. `int_ack` clears I so that service cannot be re-entered.
- Interrupt detection:
  - `int_req` passes through `SYNC_STAGES` flops, then a history flop.
  - A rising edge is `sync_out & ~hist`.
  - A rising edge sets `pending`; `int_ack` clears it.
  - If an edge and `int_ack` coincide, `pending` stays 1, so the new request is not lost.
- A level held high produces only one request. `int_req` must fall and rise again for another.
- `pending` is kept while I = 0. `interrupt` asserts as soon as I is set.
- `int_ack` while `pending` = 0 is illegal. If it occurs, the block still clears I and increments nothing.

## Timing
- Flag strobe at edge k: C/Z/I/shadows reflect it after edge k. No extra latency.
- `int_req` rise sampled at edge k:
  - `sync_out` is high after edge k+SYNC_STAGES-1.
  - `pending` is set at edge k+SYNC_STAGES.
  - `interrupt` is high in the following cycle if I = 1.
  - Total: SYNC_STAGES+1 edges.
- `interrupt` is combinational from registers only; no path from any input.
- `reset_n` assertion clears all state immediately, without waiting for a clock edge. Deassertion is synchronised externally.
- `rst` or `reset_n` mid-request discards the request. A still-high `int_req` after reset is seen as a fresh edge once the chain refills.

## Configuration
- `FLAG_INT_CNT_EN` defined:
  - 16-bit `int_count` increments on `int_ack` when `pending` = 1.
  - It saturates at 16'hFFFF and is cleared by either reset.
- `FLAG_INT_CNT_EN` undefined: the `int_count` port and its counter are absent; all other behaviour is identical.

## Structure
- Shared package `rat_pkg`: `FLG_SRC_ALU`/`FLG_SRC_SHAD` constants for `flg_ld_sel`, and the default `SYNC_STAGES`.
- Sub-module `int_sync_edge`: synchroniser chain plus history flop, outputting a one-cycle `rise` pulse. Parameterised by `SYNC_STAGES`.
- The flag registers and `pending` stay in the top module.

## Test plan
- Reset: hold `reset_n` = 0 with `int_req` = 1 → `c`, `z`, `i_flag`, `interrupt` and `int_count` are all 0. Release and wait 4 edges with `i_flag` still 0 → `interrupt` = 0.
- Flag priority: `flg_c_set` = `flg_c_clr` = `flg_c_ld` = 1 with `c_alu` = 1 → `c` = 0. Next cycle `flg_c_ld` = 1 with `c_alu` = 1 → `c` = 1.
- Shadow round-trip:
  - C = 1, Z = 0, then `flg_shad_ld` = 1 with `flg_c_clr` and `flg_z_ld` (`z_alu` = 1) in the same cycle → shadow C/Z = 1/0, live C/Z = 0/1.
  - Then `flg_ld_sel` = 1 with `flg_c_ld` and `flg_z_ld` → `c` = 1, `z` = 0.
- Interrupt latency (SYNC_STAGES = 2): `i_set`, then raise `int_req` before edge 10 → `interrupt` is high after edge 12.
  - Pulse `int_ack` → `interrupt` = 0 and `i_flag` = 0.
  - Holding `int_req` high with a later `i_set` → `interrupt` stays 0.
- Coincident edge and ack: time a second `int_req` rise so its edge lands in the same cycle as `int_ack` → `pending` stays 1. After `i_set`, `interrupt` = 1.
- Counter (`FLAG_INT_CNT_EN`): 3 serviced interrupts → `int_count` = 3. Preload near saturation and service 2 more → `int_count` = 16'hFFFF, no wrap.
